// File: rtl/y_event_logger.sv
// y_event_logger
// Capture stage for the combinational `example` output Y. Y is brought into
// the clk domain through a two-flop synchroniser, every rise and fall is
// stamped with a free-running timestamp and queued in a show-ahead FIFO, and
// a consumer drains the FIFO over a valid/ready handshake. A saturating rise
// counter and a sticky overflow flag give debug visibility into the stream.

module y_event_logger #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            y_in,
    input  logic            en,
    input  logic            rd_ready,
    input  logic            clr_ovf,
    output logic            rd_valid,
    output logic [TS_W:0]   rd_data,
    output logic            level,
    output logic [7:0]      rise_cnt,
    output logic [AW:0]     count,
    output logic            overflow
);

    // Pointer width carries one extra wrap bit so full and empty differ.
    localparam int          PW       = AW + 1;
    localparam logic [AW:0] FULL_CNT = PW'(DEPTH);

    // Synchroniser stages plus the delayed copy used for edge detection.
    logic            y_s1;
    logic            y_s2;
    logic            y_d;

    // Free-running timestamp.
    logic [TS_W-1:0] ts;

    // FIFO storage and pointers.
    logic [TS_W:0]   mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;

    // Decoded per-cycle events.
    logic            rise;
    logic            fall;
    logic            push_req;
    logic            pop;
    logic            full;
    logic            push_ok;
    logic            drop;

    // Y is asynchronous to clk: two flops resolve metastability, the third
    // remembers the previous synchronised level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_s1 <= 1'b0;
            y_s2 <= 1'b0;
            y_d  <= 1'b0;
        end else begin
            y_s1 <= y_in;
            y_s2 <= y_s1;
            y_d  <= y_s2;
        end
    end

    // Timestamp counts every cycle, independent of en, and wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
        end
    end

    // Edge decode and FIFO control. A pop in the same cycle frees a slot,
    // so a push into a full FIFO is only dropped when no pop accompanies it.
    always_comb begin
        rise     = y_s2 & ~y_d;
        fall     = ~y_s2 & y_d;
        push_req = en & (rise | fall);
        count    = wr_ptr - rd_ptr;
        full     = (count == FULL_CNT);
        rd_valid = (count != '0);
        pop      = rd_valid & rd_ready;
        push_ok  = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
    end

    // FIFO storage is cleared on reset so no stale entry survives a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= {rise, ts};
        end
    end

    // Write and read pointers advance independently on accepted push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Only rises that actually entered the FIFO are counted; stops at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_cnt <= '0;
        end else if (push_ok && rise && (rise_cnt != 8'hFF)) begin
            rise_cnt <= rise_cnt + 8'd1;
        end
    end

    // Sticky drop indicator; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Show-ahead head entry and synchronised level.
    always_comb begin
        rd_data = mem[rd_ptr[AW-1:0]];
        level   = y_s2;
    end

endmodule

// File: tb/tb_y_event_logger.sv
// tb_y_event_logger
// Directed bench for y_event_logger with a 4-bit timestamp and 8-entry FIFO.
// Stimulus pushes the expected {edge, ts} of every event that should be
// queued; a monitor pops and compares whenever the DUT hands over an entry.

module tb_y_event_logger;

    localparam int TS_W  = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          y_in     = 1'b0;
    logic          en       = 1'b0;
    logic          rd_ready = 1'b0;
    logic          clr_ovf  = 1'b0;
    logic          rd_valid;
    logic [TS_W:0] rd_data;
    logic          level;
    logic [7:0]    rise_cnt;
    logic [AW:0]   count;
    logic          overflow;

    int            vectors     = 0;
    int            miscompares = 0;
    int            cyc;
    logic [TS_W:0] exp_q [$];

    y_event_logger #(
        .TS_W  (TS_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .y_in     (y_in),
        .en       (en),
        .rd_ready (rd_ready),
        .clr_ovf  (clr_ovf),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .level    (level),
        .rise_cnt (rise_cnt),
        .count    (count),
        .overflow (overflow)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Edges since reset release; equals the DUT timestamp modulo 16.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Monitor: each accepted pop must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && rd_valid && rd_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL sb_unexpected_pop: got %b, expected no entry", rd_data);
            end else if (rd_data !== exp_q[0]) begin
                miscompares++;
                $display("[TB] FAIL sb_entry: got %b, expected %b", rd_data, exp_q[0]);
                void'(exp_q.pop_front());
            end else begin
                void'(exp_q.pop_front());
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive y_in just after an edge; the event is detected two edges later,
    // so its timestamp is the current edge count plus two.
    task automatic applyStimulus(input logic val, input logic expect_push);
        logic [TS_W-1:0] t;
        y_in = val;
        if (expect_push) begin
            t = TS_W'(cyc + 2);
            exp_q.push_back({val, t});
        end
    endtask

    task automatic drainFifo(input string name);
        rd_ready = 1'b1;
        for (int i = 0; i < 40 && rd_valid; i++) step(1);
        rd_ready = 1'b0;
        checkOutput(name, 32'(rd_valid), 32'd0);
    endtask

    initial begin
        int maxc;

        // Reset state
        step(3);
        checkOutput("rst_rd_valid", 32'(rd_valid), 0);
        checkOutput("rst_count",    32'(count),    0);
        checkOutput("rst_rise_cnt", 32'(rise_cnt), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);
        checkOutput("rst_level",    32'(level),    0);
        checkOutput("rst_rd_data",  32'(rd_data),  0);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;

        // Single pulse: rise before edge 10, fall before edge 15
        step(9);
        y_in = 1'b1;
        exp_q.push_back({1'b1, 4'd11});
        step(2);
        checkOutput("pulse_valid_e11", 32'(rd_valid), 0);
        step(1);
        checkOutput("pulse_valid_e12", 32'(rd_valid), 1);
        checkOutput("pulse_level",     32'(level),    1);
        step(2);
        y_in = 1'b0;
        exp_q.push_back({1'b0, 4'd0});
        step(3);
        checkOutput("pulse_count",    32'(count),    2);
        checkOutput("pulse_rise_cnt", 32'(rise_cnt), 1);
        checkOutput("pulse_overflow", 32'(overflow), 0);
        drainFifo("pulse_drain");

        // Overflow: 10 edges into an 8-entry FIFO, last two dropped
        for (int k = 0; k < 10; k++) begin
            applyStimulus(~y_in, k < 8);
            step(3);
        end
        step(1);
        checkOutput("ovf_count",    32'(count),    8);
        checkOutput("ovf_flag",     32'(overflow), 1);
        checkOutput("ovf_rise_cnt", 32'(rise_cnt), 5);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        checkOutput("ovf_cleared", 32'(overflow), 0);
        checkOutput("ovf_count_kept", 32'(count), 8);

        // Full FIFO with a pop in the detect cycle: push is accepted
        applyStimulus(1'b1, 1'b1);
        step(2);
        rd_ready = 1'b1;
        step(1);
        rd_ready = 1'b0;
        checkOutput("fullpop_count",    32'(count),    8);
        checkOutput("fullpop_overflow", 32'(overflow), 0);
        checkOutput("fullpop_rise_cnt", 32'(rise_cnt), 6);
        drainFifo("fullpop_drain");

        // en low: two edges ignored
        en = 1'b0;
        applyStimulus(1'b0, 1'b0);
        step(3);
        applyStimulus(1'b1, 1'b0);
        step(4);
        checkOutput("en_off_count",    32'(count),    0);
        checkOutput("en_off_rise_cnt", 32'(rise_cnt), 6);
        checkOutput("en_off_level",    32'(level),    1);

        // en high with rd_ready held: each entry leaves right after arrival
        en       = 1'b1;
        rd_ready = 1'b1;
        maxc     = 0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(~y_in, 1'b1);
            for (int j = 0; j < 3; j++) begin
                step(1);
                if (int'(count) > maxc) maxc = int'(count);
            end
        end
        step(2);
        rd_ready = 1'b0;
        checkOutput("stream_count_max", 32'(maxc),     1);
        checkOutput("stream_count_end", 32'(count),    0);
        checkOutput("stream_rise_cnt",  32'(rise_cnt), 8);

        // Timestamp wrap: events stamped 14 and then 2
        for (int i = 0; i < 20 && (cyc % 16) != 12; i++) step(1);
        if ((cyc % 16) != 12) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL wrap_align: got %0d, expected 12", cyc % 16);
        end
        y_in = 1'b0;
        exp_q.push_back({1'b0, 4'd14});
        step(4);
        y_in = 1'b1;
        exp_q.push_back({1'b1, 4'd2});
        step(4);
        checkOutput("wrap_count",    32'(count),    2);
        checkOutput("wrap_rise_cnt", 32'(rise_cnt), 9);
        drainFifo("wrap_drain");

        // Reset mid-run with 3 entries queued
        applyStimulus(1'b0, 1'b1);
        step(3);
        applyStimulus(1'b1, 1'b1);
        step(3);
        applyStimulus(1'b0, 1'b1);
        step(4);
        checkOutput("prerst_count", 32'(count), 3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_rd_valid", 32'(rd_valid), 0);
        checkOutput("midrst_count",    32'(count),    0);
        checkOutput("midrst_rise_cnt", 32'(rise_cnt), 0);
        checkOutput("midrst_overflow", 32'(overflow), 0);
        checkOutput("midrst_level",    32'(level),    0);
        exp_q.delete();

        // Y high at release is logged as a rise stamped 2
        y_in = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back({1'b1, 4'd2});
        step(2);
        checkOutput("postrst_valid_e2", 32'(rd_valid), 0);
        step(1);
        checkOutput("postrst_valid_e3", 32'(rd_valid), 1);
        checkOutput("postrst_rise_cnt", 32'(rise_cnt), 1);
        drainFifo("postrst_drain");

        checkOutput("sb_leftover", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
